// File: rtl/tb4004_pkg.sv
// Shared definitions for the LEG4 instruction memory and its loader.
// Contents:
//   DATA_W_DEF / ADR_W_DEF : default word and address widths
//   state_t                : loader FSM encoding (IDLE, LOAD, RUN)
//   NOP                    : instruction presented while the CPU is held
package tb4004_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADR_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [7:0] NOP = 8'h00;

endpackage

// File: rtl/prog_ram.sv
// Program store: DEPTH x DATA_W words, one synchronous write port and one
// registered read port. Storage has no reset so it maps onto block RAM.
// Ports:
//   clk     : clock, rising edge
//   i_we    : write enable
//   i_wadr  : write address
//   i_wdata : write data
//   i_radr  : read address, sampled every cycle
//   o_rdata : read data, one cycle after i_radr
module prog_ram
  import tb4004_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADR_W  = ADR_W_DEF
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADR_W-1:0]  i_wadr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADR_W-1:0]  i_radr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wadr] <= i_wdata;
    end
    r_rdata <= r_mem[i_radr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a sequential byte loader for the LEG4 core.
// IDLE holds the CPU, LOAD fills words 0..DEPTH-1 from a valid/ready stream,
// RUN serves mem[adr] with one cycle of latency.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-low
//   load_start : (re)start a full load from word 0
//   run_start  : go to RUN without loading (IDLE only)
//   wr_valid   : loader byte valid
//   wr_data    : loader byte
//   wr_ready   : loader may transfer this cycle
//   load_done  : one-cycle pulse on entry to RUN after the last word
//   cpu_hold   : keep CPU and program counter in reset
//   adr        : fetch address from the program counter
//   instr      : fetched instruction, NOP unless in RUN
module imem_loader
  import tb4004_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADR_W  = ADR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              run_start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              load_done,
  output logic              cpu_hold,
  input  logic [ADR_W-1:0]  adr,
  output logic [DATA_W-1:0] instr
);

  state_t             r_state;
  logic [ADR_W-1:0]   r_wr_ptr;
  logic               r_wr_ready;
  logic               r_load_done;
  logic               r_cpu_hold;
  // Set when the RAM read register holds a fetch made in RUN; otherwise
  // the instruction output is forced to NOP.
  logic               r_instr_live;

  state_t             w_state_next;
  logic [ADR_W-1:0]   w_wr_ptr_next;
  logic               w_wr_ready_next;
  logic               w_load_done_next;
  logic               w_cpu_hold_next;
  logic               w_instr_live_next;
  logic               w_we;
  logic               w_xfer;
  logic               w_last;
  logic [DATA_W-1:0]  w_rdata;

  // r_wr_ready is only ever high in LOAD, so it qualifies the handshake.
  assign w_xfer = wr_valid & r_wr_ready;
  assign w_last = (r_wr_ptr == {ADR_W{1'b1}});

  always_comb begin
    w_state_next      = r_state;
    w_wr_ptr_next     = r_wr_ptr;
    w_wr_ready_next   = 1'b0;
    w_load_done_next  = 1'b0;
    w_cpu_hold_next   = 1'b1;
    w_instr_live_next = 1'b0;
    w_we              = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          w_state_next    = ST_LOAD;
          w_wr_ptr_next   = '0;
          w_wr_ready_next = 1'b1;
        end else if (run_start) begin
          w_state_next    = ST_RUN;
          w_cpu_hold_next = 1'b0;
        end
      end
      ST_LOAD: begin
        w_wr_ready_next = 1'b1;
        if (load_start) begin
          // Restart wins over a concurrent byte, which is dropped.
          w_wr_ptr_next = '0;
        end else if (w_xfer) begin
          w_we          = 1'b1;
          w_wr_ptr_next = r_wr_ptr + 1'b1;
          if (w_last) begin
            w_state_next     = ST_RUN;
            w_wr_ready_next  = 1'b0;
            w_cpu_hold_next  = 1'b0;
            w_load_done_next = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (load_start) begin
          w_state_next    = ST_LOAD;
          w_wr_ptr_next   = '0;
          w_wr_ready_next = 1'b1;
        end else begin
          w_cpu_hold_next   = 1'b0;
          w_instr_live_next = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_wr_ready   <= 1'b0;
      r_load_done  <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_instr_live <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wr_ptr     <= w_wr_ptr_next;
      r_wr_ready   <= w_wr_ready_next;
      r_load_done  <= w_load_done_next;
      r_cpu_hold   <= w_cpu_hold_next;
      r_instr_live <= w_instr_live_next;
    end
  end

  // A reset edge aborts the load without committing the byte on the bus.
  prog_ram #(
    .DATA_W (DATA_W),
    .ADR_W  (ADR_W)
  ) u_prog_ram (
    .clk     (clk),
    .i_we    (w_we & reset),
    .i_wadr  (r_wr_ptr),
    .i_wdata (wr_data),
    .i_radr  (adr),
    .o_rdata (w_rdata)
  );

  assign wr_ready  = r_wr_ready;
  assign load_done = r_load_done;
  assign cpu_hold  = r_cpu_hold;
  assign instr     = r_instr_live ? w_rdata : DATA_W'(NOP);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver pushes the expected output
// state for the next cycle; a negedge monitor pops and compares.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_start = 1'b0;
  logic       run_start = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       load_done;
  logic       cpu_hold;
  logic [3:0] adr = 4'h0;
  logic [7:0] instr;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .run_start  (run_start),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .load_done  (load_done),
    .cpu_hold   (cpu_hold),
    .adr        (adr),
    .instr      (instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       hold;
    logic       ready;
    logic       done;
    logic [7:0] ins;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_seen = 0;
  int         done_exp = 0;
  bit         end_req = 1'b0;
  logic [7:0] model [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs after the next rising edge.
  task automatic exp_st(string tag, logic h, logic r, logic d, logic [7:0] i);
    exp_t e;
    e.cyc = cyc + 1;
    e.hold = h;
    e.ready = r;
    e.done = d;
    e.ins = i;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic start_load(string tag);
    load_start = 1'b1;
    exp_st(tag, 1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(string tag, logic [7:0] b, bit last, int gap);
    repeat (gap) begin
      wr_valid = 1'b0;
      exp_st(tag, 1'b1, 1'b1, 1'b0, 8'h00);
      tick();
    end
    wr_valid = 1'b1;
    wr_data = b;
    if (last) begin
      exp_st(tag, 1'b0, 1'b0, 1'b1, 8'h00);
      done_exp++;
    end else begin
      exp_st(tag, 1'b1, 1'b1, 1'b0, 8'h00);
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic send16(string tag, logic [7:0] base, int gap);
    for (int i = 0; i < 16; i++) begin
      send(tag, 8'(base + i), (i == 15), gap);
      model[i] = 8'(base + i);
    end
  endtask

  task automatic rd(string tag, int a);
    adr = 4'(a);
    exp_st(tag, 1'b0, 1'b0, 1'b0, model[a]);
    tick();
  endtask

  task automatic sweep(string tag);
    for (int a = 0; a < 16; a++) rd(tag, a);
  endtask

  task automatic chk(string tag, string f, logic [7:0] got, logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s %s at cyc %0d: got %h want %h", tag, f, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (load_done === 1'b1) done_seen++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s stale expectation: got cyc %0d want %0d", e.tag, cyc, e.cyc);
      end else begin
        $display("cyc %0d %s: hold=%b ready=%b done=%b instr=%h", cyc, e.tag,
                 cpu_hold, wr_ready, load_done, instr);
        chk(e.tag, "cpu_hold",  {7'b0, cpu_hold},  {7'b0, e.hold});
        chk(e.tag, "wr_ready",  {7'b0, wr_ready},  {7'b0, e.ready});
        chk(e.tag, "load_done", {7'b0, load_done}, {7'b0, e.done});
        chk(e.tag, "instr",     instr,             e.ins);
      end
    end
    if (end_req) begin
      n_cmp++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      chk("final", "load_done_pulses", 8'(done_seen), 8'(done_exp));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset held two cycles, then idle with no requests
    exp_st("t1_rst", 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    exp_st("t1_rst", 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    reset = 1'b1;
    repeat (3) begin
      exp_st("t1_idle", 1'b1, 1'b0, 1'b0, 8'h00);
      tick();
    end

    // 2: back-to-back load 0x10..0x1F
    start_load("t2_start");
    send16("t2_load", 8'h10, 0);
    rd("t2_rd5", 5);
    rd("t2_rd15", 15);

    // 3: load with a gap before every byte, full sweep
    start_load("t3_start");
    send16("t3_load", 8'h40, 1);
    sweep("t3_sweep");

    // 5: reset during a partial load keeps the words already written
    start_load("t5_start");
    for (int i = 0; i < 8; i++) begin
      send("t5_load", 8'(8'h50 + i), 1'b0, 0);
      model[i] = 8'(8'h50 + i);
    end
    reset = 1'b0;
    exp_st("t5_rst", 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    reset = 1'b1;
    exp_st("t5_idle", 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    run_start = 1'b1;
    exp_st("t5_run", 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    run_start = 1'b0;
    sweep("t5_sweep");

    // 4: restart mid-load discards the concurrent byte
    start_load("t4_start");
    for (int i = 0; i < 6; i++) send("t4_part", 8'(8'hA0 + i), 1'b0, 0);
    load_start = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'hA6;
    exp_st("t4_restart", 1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    load_start = 1'b0;
    wr_valid = 1'b0;
    send16("t4_load", 8'h30, 0);
    sweep("t4_sweep");

    // 6: load_start beats run_start in IDLE; load_start from RUN
    reset = 1'b0;
    exp_st("t6_rst", 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    reset = 1'b1;
    exp_st("t6_idle", 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    load_start = 1'b1;
    run_start = 1'b1;
    exp_st("t6_both", 1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    load_start = 1'b0;
    run_start = 1'b0;
    send16("t6_load", 8'h60, 0);
    rd("t6_rd3", 3);
    load_start = 1'b1;
    exp_st("t6_reload", 1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    load_start = 1'b0;
    exp_st("t6_inload", 1'b1, 1'b1, 1'b0, 8'h00);
    tick();

    repeat (2) tick();
    end_req = 1'b1;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program memory and its loader for the LEG4 core: the storage side the program counter reads from. Holds a DEPTH x DATA_W instruction store, filled sequentially over a valid/ready byte stream from the host or test interface. In RUN it serves the instruction at the address driven by the program counter. While loading it holds the CPU in reset through cpu_hold.

Parameters:
DATA_W, 8, instruction word width
ADR_W, 4, address width, matches the program counter output
DEPTH, 16, number of words; fixed at 2**ADR_W

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
load_start  in  1  request (re)load of the whole memory from word 0
run_start  in  1  request execution without loading (IDLE only)
wr_valid  in  1  loader byte valid
wr_data  in  DATA_W  loader byte
wr_ready  out  1  loader may transfer this cycle
load_done  out  1  one-cycle pulse after last word written
cpu_hold  out  1  hold CPU and program counter in reset
adr  in  ADR_W  fetch address from program counter
instr  out  DATA_W  fetched instruction, registered

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, wr_ptr=0, wr_ready=0, load_done=0, cpu_hold=1, instr=0 (NOP).
  - Memory contents are NOT cleared.
  - Reset mid-load aborts the load; words already written stay written.
- States IDLE, LOAD, RUN. All outputs registered.
- IDLE:
  - cpu_hold=1, instr=0.
  - load_start=1 -> LOAD with wr_ptr=0.
  - else run_start=1 -> RUN.
  - If both are asserted, load_start wins.
- LOAD:
  - wr_ready=1 from the first cycle in LOAD; cpu_hold=1; instr=0.
  - Transfer = wr_valid & wr_ready: mem[wr_ptr] <= wr_data, wr_ptr <= wr_ptr+1.
  - Gaps in wr_valid are allowed; only handshakes count.
  - Transfer with wr_ptr==DEPTH-1: wr_ptr wraps to 0. Next state RUN: wr_ready=0, cpu_hold=0, load_done=1 for exactly that one cycle.
  - load_start=1 in LOAD restarts the load: wr_ptr=0, and any concurrent byte is discarded (no write). Priority: load_start > transfer.
  - run_start is ignored in LOAD.
- RUN:
  - cpu_hold=0, wr_ready=0.
  - instr <= mem[adr] every cycle: 1-cycle read latency, so instr at cycle n+1 reflects adr at cycle n.
  - load_start=1 -> LOAD next cycle: cpu_hold=1, instr=0, wr_ptr=0.
  - wr_valid is ignored in RUN.
- load_done is never asserted outside the single cycle on entry to RUN from LOAD.
- Reads and writes never occur in the same state, so there is no read/write collision case.

Decomposition:
- Package tb4004_pkg: DATA_W/ADR_W defaults, state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2), NOP constant 8'h00.
- Sub-module prog_ram: DEPTH x DATA_W register file, one synchronous write port (we, wadr, wdata) and one registered read port (radr, rdata), no reset on storage.
- The FSM, wr_ptr and output registers live in imem_loader.

Test Plan:
1. Hold reset=0 for 2 cycles -> cpu_hold=1, wr_ready=0, load_done=0, instr=0x00. After release with no requests, the block stays in IDLE.
2. load_start pulse, then 16 back-to-back bytes 0x10..0x1F -> load_done high exactly one cycle after the 16th handshake, cpu_hold=0 that cycle. adr=5 -> instr=0x15 one cycle later; adr=15 -> 0x1F.
3. Load with wr_valid toggling every other cycle, bytes 0x40..0x4F -> exactly 16 writes, no duplicates; adr sweep 0..15 returns 0x40..0x4F in order.
4. Load 6 bytes 0xA0..0xA5, then assert load_start together with wr_valid on byte 0xA6 -> 0xA6 discarded. Then 16 bytes 0x30..0x3F -> mem[0..15]=0x30..0x3F, no 0xAx left.
5. After test 3, start a load and send 8 bytes 0x50..0x57, then reset=0 -> IDLE, wr_ready=0. Then run_start -> RUN: mem[0..7]=0x50..0x57, mem[8..15]=0x48..0x4F.
6. In IDLE assert load_start and run_start in the same cycle -> LOAD (wr_ready=1, cpu_hold=1). In RUN assert load_start -> cpu_hold=1 and instr=0x00 next cycle.
